fsm_seq: RTL and testbench
==========================

Name: fsm_seq

Overview:
Parametrised successor to the fixed 3-state fsm. The state register is held inside the block instead of being fed back from the bench.
- Supports NUM_STATES states.
- Each state has its own advance condition, and every state enforces a minimum dwell time.
- Two sequencing modes: ring and ping-pong.
- Supports a synchronous state load.
It is a drop-in sequencer for test harnesses and for control paths that step through phases.

Parameters:
- NUM_STATES, 3, number of states, >=1.
- DWELL_W, 4, width of the dwell threshold and of the dwell counter.
- MODE, 0, 0 = ring (0..N-1, 0..), 1 = ping-pong (0..N-1..0..).
- SW, derived, max(1, clog2(NUM_STATES)), width of the state index. Localparam, not overridable.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  global step enable; when 0 the whole block freezes.
- adv  in  NUM_STATES  per-state advance condition; adv[k] is examined only while in state k.
- dwell  in  DWELL_W  minimum extra cycles spent in a state before it may advance.
- load  in  1  synchronous load strobe.
- load_state  in  SW  state index to load.
- y  out  SW  current state index (registered).
- y_onehot  out  NUM_STATES  one-hot decode of y (registered, consistent with y).
- dir  out  1  ping-pong direction, 1 = descending; constant 0 in ring mode.
- wrap  out  1  one-cycle pulse; see Behaviour.

Behaviour:
- Reset (reset_n=0, asynchronous): y=0, y_onehot=1, dir=0, wrap=0, dwell counter cnt=0. Deassertion is applied at the next rising edge.
- en=0: y, y_onehot, dir and cnt hold; wrap=0 on the next edge. load is ignored.
- en=1 and load=1 (load has priority over advance):
  - If load_state < NUM_STATES: y<=load_state, cnt<=0, wrap<=0, dir unchanged.
  - If load_state >= NUM_STATES: the load is ignored, and the cycle behaves as load=0.
- en=1, load=0: advance condition go = (cnt >= dwell) && adv[y].
  - go=0: cnt<=cnt+1, saturating at all-ones; y holds; wrap<=0.
  - go=1: y<=next, cnt<=0.
  - dwell is sampled live every cycle, not latched on state entry.
- Ring next state:
  - y==N-1 → 0, with wrap<=1.
  - Otherwise y+1, with wrap<=0.
- Ping-pong next state:
  - dir=0, y<N-1: y+1.
  - dir=0, y==N-1: N-2, dir<=1, wrap<=1.
  - dir=1, y>0: y-1.
  - dir=1, y==0: 1, dir<=0, wrap<=1.
- NUM_STATES=1: y stays 0; every go pulses wrap; dir stays 0.
- NUM_STATES=2, ping-pong: alternates 0,1,0,1; wrap on every advance.
- Timing and latency:
  - With dwell=0 and adv held at 1, y changes every enabled cycle.
  - With dwell=D, each state is held D+1 enabled cycles.
  - wrap is asserted in the same cycle that y shows the post-wrap state.
- Reset asserted mid-sequence takes effect immediately, with no clock required.
- Assertions (verification):
  - y < NUM_STATES at all times.
  - y_onehot == 1<<y.
  - wrap never asserted on two consecutive cycles unless every state has go=1.

Decomposition:
- Package fsm_pkg holds:
  - mode constants MODE_RING=0 and MODE_PINGPONG=1;
  - a clog2-with-min-1 function used for SW.
- Sub-module fsm_dwell_cnt (DWELL_W):
  - inputs: clock, reset_n, en, clr, dwell;
  - output: ready = cnt >= dwell;
  - implements the saturating counter.
- The top level contains the next-state, direction, wrap and one-hot logic.

Test Plan:
- Ring, N=3, dwell=0, adv=3'b111, en=1 after 16 cycles of reset: y = 0,1,2,0,1,2.
- Ring, N=3, dwell=2, adv=all ones: each y value held 3 cycles; wrap high only in the first cycle of each return to 0 (every 9 cycles).
- Ping-pong, N=4, dwell=0, adv all ones:
  - y = 0,1,2,3,2,1,0,1;
  - dir rises in the cycle y first shows 2 after 3;
  - wrap pulses when y shows 2 after 3, and when y shows 1 after 0.
- Gating, N=3, adv=3'b101: sequence stalls in state 1 with cnt saturating to 15. Setting adv[1]=1 for one cycle advances to 2, then continues to 0.
- Load and priority:
  - load=1, load_state=2 while go=1 in state 0: y=2 next cycle, cnt=0, wrap=0.
  - load_state=3 with N=3: load ignored; normal advance to 1.
- Reset and freeze:
  - reset_n pulled low mid-cycle while y=2: y=0, y_onehot=001, wrap=0 before the next clock edge.
  - en=0 for 5 cycles: all outputs frozen.

Source files
------------

// File: rtl/fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module : fsm_pkg
// Shared mode constants, direction type and index-width helper for fsm_seq.
// Rev    : 1.0
// ============================================================================
package fsm_pkg;

    localparam int MODE_RING     = 0;
    localparam int MODE_PINGPONG = 1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // A single state still needs a one-bit index
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_dwell_cnt.sv
`default_nettype none
// ============================================================================
// Module : fsm_dwell_cnt
// Saturating per-state dwell counter; ready once the count reaches dwell.
// Rev    : 1.0
// ============================================================================
module fsm_dwell_cnt #(
    parameter int DWELL_W = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               en,
    input  logic               clr,
    input  logic [DWELL_W-1:0] dwell,
    output logic               ready
);

    logic [DWELL_W-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (en) begin
            if (clr) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign ready = (r_cnt >= dwell);

endmodule
`default_nettype wire

// File: rtl/fsm_seq.sv
`default_nettype none
// ============================================================================
// Module : fsm_seq
// Parametrised ring / ping-pong phase sequencer with per-state dwell and load.
// Rev    : 1.0
// ============================================================================
module fsm_seq
    import fsm_pkg::*;
#(
    parameter  int NUM_STATES = 3,
    parameter  int DWELL_W    = 4,
    parameter  int MODE       = MODE_RING,
    localparam int SW         = clog2_min1(NUM_STATES)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [NUM_STATES-1:0] adv,
    input  logic [DWELL_W-1:0]    dwell,
    input  logic                  load,
    input  logic [SW-1:0]         load_state,
    output logic [SW-1:0]         y,
    output logic [NUM_STATES-1:0] y_onehot,
    output logic                  dir,
    output logic                  wrap
);

    localparam logic [SW-1:0] c_LAST     = SW'(NUM_STATES - 1);
    localparam logic [SW-1:0] c_PENULT   = SW'((NUM_STATES >= 2) ? NUM_STATES - 2 : 0);
    localparam logic [SW-1:0] c_FIRST_UP = SW'((NUM_STATES >= 2) ? 1 : 0);

    logic [SW-1:0]         r_y;
    logic [NUM_STATES-1:0] r_onehot;
    dir_e                  r_dir;
    logic                  r_wrap;

    logic                  w_ready;
    logic                  w_adv_cur;
    logic                  w_go;
    logic                  w_load_ok;
    logic                  w_clr;
    logic [31:0]           w_ls_ext;
    logic [SW-1:0]         w_step_y;
    dir_e                  w_step_dir;
    logic                  w_step_wrap;

    // The one-hot register doubles as the selector for the current advance bit
    assign w_adv_cur = |(adv & r_onehot);
    assign w_go      = w_ready & w_adv_cur;
    assign w_ls_ext  = 32'(load_state);
    assign w_load_ok = load && (w_ls_ext < 32'(NUM_STATES));
    assign w_clr     = w_load_ok | w_go;

    fsm_dwell_cnt #(
        .DWELL_W (DWELL_W)
    ) u_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (en),
        .clr     (w_clr),
        .dwell   (dwell),
        .ready   (w_ready)
    );

    always_comb begin
        w_step_y    = r_y;
        w_step_dir  = r_dir;
        w_step_wrap = 1'b0;
        if (NUM_STATES == 1) begin
            w_step_y    = '0;
            w_step_dir  = DIR_UP;
            w_step_wrap = 1'b1;
        end else if (MODE == MODE_PINGPONG) begin
            if (r_dir == DIR_UP) begin
                if (r_y == c_LAST) begin
                    w_step_y    = c_PENULT;
                    w_step_dir  = DIR_DOWN;
                    w_step_wrap = 1'b1;
                end else begin
                    w_step_y = r_y + 1'b1;
                end
            end else begin
                if (r_y == '0) begin
                    w_step_y    = c_FIRST_UP;
                    w_step_dir  = DIR_UP;
                    w_step_wrap = 1'b1;
                end else begin
                    w_step_y = r_y - 1'b1;
                end
            end
        end else begin
            if (r_y == c_LAST) begin
                w_step_y    = '0;
                w_step_wrap = 1'b1;
            end else begin
                w_step_y = r_y + 1'b1;
            end
        end
    end

    // A load wins over an advance; an out-of-range load falls through to it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_y      <= '0;
            r_onehot <= NUM_STATES'(1);
            r_dir    <= DIR_UP;
            r_wrap   <= 1'b0;
        end else if (en) begin
            r_wrap <= 1'b0;
            if (w_load_ok) begin
                r_y      <= load_state;
                r_onehot <= NUM_STATES'(1) << load_state;
            end else if (w_go) begin
                r_y      <= w_step_y;
                r_onehot <= NUM_STATES'(1) << w_step_y;
                r_dir    <= w_step_dir;
                r_wrap   <= w_step_wrap;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign y        = r_y;
    assign y_onehot = r_onehot;
    assign dir      = r_dir;
    assign wrap     = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_fsm_seq.sv
`default_nettype none
// Bench for fsm_seq: a ring N=3 instance and a ping-pong N=4 instance
// driven from vector tables plus hand-written corner sequences.
module tb_fsm_seq;

    typedef struct {
        logic       en;
        logic       load;
        logic [1:0] ls;
        logic [2:0] adv;
        logic [3:0] dwell;
        logic [1:0] ey;
        logic       ew;
    } vec_t;

    typedef struct {
        int    y;
        int    oh;
        int    dir;
        int    wrap;
        string tag;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic       ring_en, ring_load;
    logic [1:0] ring_ls;
    logic [2:0] ring_adv;
    logic [3:0] ring_dwell;
    logic [1:0] ring_y;
    logic [2:0] ring_oh;
    logic       ring_dir, ring_wrap;

    logic       pp_en, pp_load;
    logic [1:0] pp_ls;
    logic [3:0] pp_adv;
    logic [3:0] pp_dwell;
    logic [1:0] pp_y;
    logic [3:0] pp_oh;
    logic       pp_dir, pp_wrap;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[$];
    exp_t sb_q[$];
    logic ring_wrap_prev = 1'b0;
    logic pp_wrap_prev   = 1'b0;

    fsm_seq #(.NUM_STATES(3), .DWELL_W(4), .MODE(0)) u_ring (
        .clock      (clock),
        .reset_n    (reset_n),
        .en         (ring_en),
        .adv        (ring_adv),
        .dwell      (ring_dwell),
        .load       (ring_load),
        .load_state (ring_ls),
        .y          (ring_y),
        .y_onehot   (ring_oh),
        .dir        (ring_dir),
        .wrap       (ring_wrap)
    );

    fsm_seq #(.NUM_STATES(4), .DWELL_W(4), .MODE(1)) u_pp (
        .clock      (clock),
        .reset_n    (reset_n),
        .en         (pp_en),
        .adv        (pp_adv),
        .dwell      (pp_dwell),
        .load       (pp_load),
        .load_state (pp_ls),
        .y          (pp_y),
        .y_onehot   (pp_oh),
        .dir        (pp_dir),
        .wrap       (pp_wrap)
    );

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic sb_check(input int y, input int oh, input int d, input int w);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: got output with no expectation, expected 1 entry");
        end else begin
            e = sb_q.pop_front();
            chk({e.tag, ".y"},    y,  e.y);
            chk({e.tag, ".oh"},   oh, e.oh);
            chk({e.tag, ".dir"},  d,  e.dir);
            chk({e.tag, ".wrap"}, w,  e.wrap);
        end
    endtask

    function automatic void add(input logic en, input logic ld, input logic [1:0] ls,
                                input logic [2:0] a, input logic [3:0] d,
                                input logic [1:0] ey, input logic ew);
        tbl.push_back('{en, ld, ls, a, d, ey, ew});
    endfunction

    task automatic ring_step(input vec_t v, input string tag);
        exp_t e;
        ring_en    = v.en;
        ring_load  = v.load;
        ring_ls    = v.ls;
        ring_adv   = v.adv;
        ring_dwell = v.dwell;
        e.y    = int'(v.ey);
        e.oh   = 1 << v.ey;
        e.dir  = 0;
        e.wrap = int'(v.ew);
        e.tag  = tag;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        sb_check(int'(ring_y), int'(ring_oh), int'(ring_dir), int'(ring_wrap));
    endtask

    task automatic pp_step(input int ey, input int ed, input int ew, input string tag);
        exp_t e;
        pp_en    = 1'b1;
        pp_adv   = 4'b1111;
        pp_dwell = 4'd0;
        e.y    = ey;
        e.oh   = 1 << ey;
        e.dir  = ed;
        e.wrap = ew;
        e.tag  = tag;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        sb_check(int'(pp_y), int'(pp_oh), int'(pp_dir), int'(pp_wrap));
    endtask

    // Structural invariants, sampled away from the active edge
    always @(negedge clock) begin
        if (reset_n) begin
            chk("inv_ring_range",  int'(ring_y < 2'd3), 1);
            chk("inv_ring_onehot", int'(ring_oh), 1 << ring_y);
            chk("inv_pp_onehot",   int'(pp_oh),   1 << pp_y);
            chk("inv_ring_wrap2",  int'(ring_wrap && ring_wrap_prev), 0);
            chk("inv_pp_wrap2",    int'(pp_wrap && pp_wrap_prev), 0);
            ring_wrap_prev = ring_wrap;
            pp_wrap_prev   = pp_wrap;
        end else begin
            ring_wrap_prev = 1'b0;
            pp_wrap_prev   = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pp_y_exp[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
        int pp_d_exp[8] = '{0, 0, 0, 1, 1, 1, 0, 0};
        int pp_w_exp[8] = '{0, 0, 0, 1, 0, 0, 1, 0};
        int ring_t2[12] = '{0, 0, 1, 1, 1, 2, 2, 2, 0, 0, 0, 1};

        reset_n    = 1'b0;
        ring_en    = 1'b0; ring_load = 1'b0; ring_ls = 2'd0; ring_adv = 3'd0; ring_dwell = 4'd0;
        pp_en      = 1'b0; pp_load   = 1'b0; pp_ls   = 2'd0; pp_adv   = 4'd0; pp_dwell   = 4'd0;

        // Ring: dwell 0, every state ready
        for (int i = 0; i < 6; i++)
            add(1'b1, 1'b0, 2'd0, 3'b111, 4'd0, 2'((i + 1) % 3), ((i % 3) == 2));
        // Ring: dwell 2, three cycles per state
        for (int i = 0; i < 12; i++)
            add(1'b1, 1'b0, 2'd0, 3'b111, 4'd2, 2'(ring_t2[i]), (i == 8));
        // Load to 0, stall to build count, then load 2 overriding a go in state 0
        add(1'b1, 1'b1, 2'd0, 3'b111, 4'd0, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++)
            add(1'b1, 1'b0, 2'd0, 3'b000, 4'd0, 2'd0, 1'b0);
        add(1'b1, 1'b1, 2'd2, 3'b111, 4'd0, 2'd2, 1'b0);
        add(1'b1, 1'b0, 2'd0, 3'b111, 4'd1, 2'd2, 1'b0);
        add(1'b1, 1'b0, 2'd0, 3'b111, 4'd1, 2'd0, 1'b1);
        // Freeze: everything holds, wrap drops, load ignored
        for (int i = 0; i < 5; i++)
            add(1'b0, 1'b1, 2'd1, 3'b111, 4'd0, 2'd0, 1'b0);
        // Out-of-range load behaves as a plain advance
        add(1'b1, 1'b1, 2'd3, 3'b111, 4'd0, 2'd1, 1'b0);

        repeat (16) @(posedge clock);
        #1;
        chk("rst_ring_y",    int'(ring_y),    0);
        chk("rst_ring_oh",   int'(ring_oh),   1);
        chk("rst_ring_dir",  int'(ring_dir),  0);
        chk("rst_ring_wrap", int'(ring_wrap), 0);
        chk("rst_pp_y",      int'(pp_y),      0);
        chk("rst_pp_oh",     int'(pp_oh),     1);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            ring_step(tbl[i], $sformatf("ring_vec%0d", i));

        // Stall in state 1 long enough to saturate the counter
        for (int i = 0; i < 20; i++)
            ring_step('{1'b1, 1'b0, 2'd0, 3'b101, 4'd0, 2'd1, 1'b0}, $sformatf("gate_stall%0d", i));
        ring_step('{1'b1, 1'b0, 2'd0, 3'b111, 4'd15, 2'd2, 1'b0}, "gate_release");
        ring_step('{1'b1, 1'b0, 2'd0, 3'b101, 4'd0, 2'd0, 1'b1}, "gate_continue");

        // Reach state 2, then assert reset between edges
        ring_step('{1'b1, 1'b0, 2'd0, 3'b111, 4'd0, 2'd1, 1'b0}, "pre_rst1");
        ring_step('{1'b1, 1'b0, 2'd0, 3'b111, 4'd0, 2'd2, 1'b0}, "pre_rst2");
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_y",    int'(ring_y),    0);
        chk("async_rst_oh",   int'(ring_oh),   1);
        chk("async_rst_wrap", int'(ring_wrap), 0);
        chk("async_rst_dir",  int'(ring_dir),  0);
        ring_en = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Ping-pong N=4
        for (int i = 0; i < 8; i++)
            pp_step(pp_y_exp[i], pp_d_exp[i], pp_w_exp[i], $sformatf("pp%0d", i));
        pp_en = 1'b0;
        @(posedge clock);
        #1;

        chk("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
